// File: rtl/intr_pkg.sv
// Shared encodings for the interrupt controller: FSM states, mask bit layout, vector ids.
package intr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_SERVICE = 2'd2
   } intr_state_t;

   localparam int EN1_BIT = 0;
   localparam int EN2_BIT = 1;
   localparam int GIE_BIT = 7;

   // Writable mask bits; everything else reads back as zero.
   localparam logic [7:0] MASK_BITS = 8'h83;

   localparam logic VEC1_ID = 1'b0;
   localparam logic VEC2_ID = 1'b1;

   localparam int HOLDOFF_W = 4;

endpackage

// File: rtl/intr_controller_sync_edge.sv
// Per-line synchronizer chain followed by a rising-edge detector.
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_irq,
   output logic o_edge
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   // Decoded from flops only, so the pulse is clean for one full cycle.
   assign o_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/intr_controller.sv
// Interrupt initiator: latches irq edges, masks, arbitrates (vec1 first) and issues one-cycle
// vector-select pulses, then waits for return-from-interrupt plus a holdoff before the next.
module intr_controller
   import intr_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int HOLDOFF     = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] irq,
   input  logic       mask_we,
   input  logic [7:0] mask_in,
   input  logic       int_ret,
   output logic       s_intr1,
   output logic       s_intr2,
   output logic       busy,
   output logic [1:0] pending,
   output logic [7:0] mask_q
);

   intr_state_t          r_state;
   logic [1:0]           r_pending;
   logic [7:0]           r_mask_q;
   logic [HOLDOFF_W-1:0] r_holdoff;
   logic                 r_s_intr1;
   logic                 r_s_intr2;

   logic [1:0] w_edge;
   logic [1:0] w_eligible;
   logic       w_dispatch;
   logic       w_win_id;
   logic [1:0] w_clear;

   for (genvar g = 0; g < 2; g++) begin : g_sync
      irq_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk    (clk),
         .reset  (reset),
         .i_irq  (irq[g]),
         .o_edge (w_edge[g])
      );
   end

   assign w_eligible = r_pending
                     & {r_mask_q[EN2_BIT], r_mask_q[EN1_BIT]}
                     & {2{r_mask_q[GIE_BIT]}};
   assign w_dispatch = (r_state == ST_IDLE) && (w_eligible != 2'b00) && (r_holdoff == '0);
   assign w_win_id   = w_eligible[0] ? VEC1_ID : VEC2_ID;
   assign w_clear    = !w_dispatch ? 2'b00 : ((w_win_id == VEC1_ID) ? 2'b01 : 2'b10);

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mask_q <= '0;
      end else if (mask_we) begin
         r_mask_q <= mask_in & MASK_BITS;
      end
   end

   // A fresh edge wins over the dispatch clear in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_clear) | w_edge;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= ST_IDLE;
         r_holdoff <= '0;
         r_s_intr1 <= 1'b0;
         r_s_intr2 <= 1'b0;
      end else begin
         r_s_intr1 <= 1'b0;
         r_s_intr2 <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_dispatch) begin
                  r_state   <= ST_ISSUE;
                  r_s_intr1 <= (w_win_id == VEC1_ID);
                  r_s_intr2 <= (w_win_id == VEC2_ID);
               end else if (r_holdoff != '0) begin
                  r_holdoff <= r_holdoff - 1'b1;
               end
            end
            ST_ISSUE: begin
               r_state <= ST_SERVICE;
            end
            ST_SERVICE: begin
               if (int_ret) begin
                  r_state   <= ST_IDLE;
                  r_holdoff <= HOLDOFF_W'(HOLDOFF);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign s_intr1 = r_s_intr1;
   assign s_intr2 = r_s_intr2;
   assign busy    = (r_state != ST_IDLE);
   assign pending = r_pending;
   assign mask_q  = r_mask_q;

endmodule

// File: tb/tb_intr_controller.sv
// Directed bench for intr_controller: cycle-exact checks of dispatch timing, masking and reset.
module tb_intr_controller;

   logic       clk;
   logic       reset;
   logic [1:0] irq;
   logic       mask_we;
   logic [7:0] mask_in;
   logic       int_ret;
   logic       s_intr1;
   logic       s_intr2;
   logic       busy;
   logic [1:0] pending;
   logic [7:0] mask_q;

   int n_vec  = 0;
   int n_miss = 0;

   intr_controller #(
      .SYNC_STAGES (2),
      .HOLDOFF     (1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .irq     (irq),
      .mask_we (mask_we),
      .mask_in (mask_in),
      .int_ret (int_ret),
      .s_intr1 (s_intr1),
      .s_intr2 (s_intr2),
      .busy    (busy),
      .pending (pending),
      .mask_q  (mask_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic wr_mask(input logic [7:0] v);
      mask_we = 1'b1;
      mask_in = v;
      tick();
      mask_we = 1'b0;
   endtask

   task automatic ret_pulse();
      int_ret = 1'b1;
      tick();
      int_ret = 1'b0;
   endtask

   initial begin
      reset   = 1'b0;
      irq     = 2'b00;
      mask_we = 1'b0;
      mask_in = 8'h00;
      int_ret = 1'b0;
      ticks(3);
      check("rst_busy", {7'b0, busy}, 8'h00);
      check("rst_pend", {6'b0, pending}, 8'h00);
      check("rst_mask", mask_q, 8'h00);
      check("rst_s1", {7'b0, s_intr1}, 8'h00);
      check("rst_s2", {7'b0, s_intr2}, 8'h00);
      reset = 1'b1;
      tick();

      // 1: single source latency
      wr_mask(8'hff);
      check("t1_mask_unused0", mask_q, 8'h83);
      wr_mask(8'h81);
      check("t1_mask", mask_q, 8'h81);
      irq = 2'b01;
      tick();
      check("t1_pend_k", {6'b0, pending}, 8'h00);
      tick();
      check("t1_pend_k1", {6'b0, pending}, 8'h00);
      tick();
      check("t1_pend_k2", {6'b0, pending}, 8'h01);
      check("t1_s1_k2", {7'b0, s_intr1}, 8'h00);
      tick();
      check("t1_s1_k3", {7'b0, s_intr1}, 8'h01);
      check("t1_s2_k3", {7'b0, s_intr2}, 8'h00);
      check("t1_busy_k3", {7'b0, busy}, 8'h01);
      check("t1_pend_k3", {6'b0, pending}, 8'h00);
      tick();
      check("t1_s1_k4", {7'b0, s_intr1}, 8'h00);
      check("t1_busy_k4", {7'b0, busy}, 8'h01);
      ret_pulse();
      check("t1_busy_ret", {7'b0, busy}, 8'h00);
      irq = 2'b00;
      ticks(4);

      // 2: simultaneous sources, vec1 first, vec2 after holdoff
      wr_mask(8'h83);
      irq = 2'b11;
      ticks(3);
      check("t2_pend", {6'b0, pending}, 8'h03);
      tick();
      check("t2_s1", {7'b0, s_intr1}, 8'h01);
      check("t2_s2_excl", {7'b0, s_intr2}, 8'h00);
      check("t2_pend_after1", {6'b0, pending}, 8'h02);
      tick();
      ret_pulse();
      check("t2_busy_ret", {7'b0, busy}, 8'h00);
      tick();
      check("t2_s2_hold", {7'b0, s_intr2}, 8'h00);
      tick();
      check("t2_s2", {7'b0, s_intr2}, 8'h01);
      check("t2_pend_after2", {6'b0, pending}, 8'h00);
      tick();
      ret_pulse();
      irq = 2'b00;
      ticks(4);

      // 3: GIE off retains pending; enabling dispatches a cycle after the write
      wr_mask(8'h01);
      irq = 2'b01;
      ticks(6);
      check("t3_pend", {6'b0, pending}, 8'h01);
      check("t3_s1_gated", {7'b0, s_intr1}, 8'h00);
      check("t3_busy_gated", {7'b0, busy}, 8'h00);
      mask_we = 1'b1;
      mask_in = 8'h81;
      tick();
      mask_we = 1'b0;
      check("t3_s1_wr_edge", {7'b0, s_intr1}, 8'h00);
      check("t3_mask", mask_q, 8'h81);
      tick();
      check("t3_s1", {7'b0, s_intr1}, 8'h01);
      tick();

      // 4: repeated edges in service collapse to one pending request
      irq = 2'b00;
      ticks(3);
      for (int i = 0; i < 3; i++) begin
         irq = 2'b01;
         tick();
         irq = 2'b00;
         ticks(2);
      end
      ticks(3);
      check("t4_pend", {6'b0, pending}, 8'h01);
      check("t4_busy", {7'b0, busy}, 8'h01);
      ret_pulse();
      tick();
      check("t4_s1_hold", {7'b0, s_intr1}, 8'h00);
      tick();
      check("t4_s1", {7'b0, s_intr1}, 8'h01);
      check("t4_pend_clr", {6'b0, pending}, 8'h00);
      tick();
      ret_pulse();
      ticks(4);
      check("t4_no_extra", {7'b0, s_intr1}, 8'h00);
      check("t4_idle", {7'b0, busy}, 8'h00);

      // 7: edge arriving in the dispatch cycle keeps the pending bit set
      wr_mask(8'h01);
      irq = 2'b01;
      tick();
      irq = 2'b00;
      ticks(4);
      check("t7_pend_pre", {6'b0, pending}, 8'h01);
      irq = 2'b01;
      tick();
      mask_we = 1'b1;
      mask_in = 8'h81;
      tick();
      mask_we = 1'b0;
      check("t7_s1_wr_edge", {7'b0, s_intr1}, 8'h00);
      tick();
      check("t7_s1", {7'b0, s_intr1}, 8'h01);
      check("t7_pend_setwins", {6'b0, pending}, 8'h01);
      tick();
      ret_pulse();
      ticks(2);
      check("t7_s1_again", {7'b0, s_intr1}, 8'h01);
      check("t7_pend_clr", {6'b0, pending}, 8'h00);
      tick();
      ret_pulse();
      irq = 2'b00;
      ticks(4);

      // 5: reset in service
      wr_mask(8'h83);
      irq = 2'b11;
      ticks(5);
      check("t5_pend", {6'b0, pending}, 8'h02);
      check("t5_busy", {7'b0, busy}, 8'h01);
      irq = 2'b00;
      reset = 1'b0;
      tick();
      check("t5_busy_rst", {7'b0, busy}, 8'h00);
      check("t5_pend_rst", {6'b0, pending}, 8'h00);
      check("t5_mask_rst", mask_q, 8'h00);
      check("t5_s1_rst", {7'b0, s_intr1}, 8'h00);
      check("t5_s2_rst", {7'b0, s_intr2}, 8'h00);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t5_s2_quiet", {7'b0, s_intr2}, 8'h00);
      end

      // 6: int_ret outside service ignored; mask write at dispatch uses old mask
      wr_mask(8'h81);
      int_ret = 1'b1;
      ticks(2);
      int_ret = 1'b0;
      check("t6_busy_idle_ret", {7'b0, busy}, 8'h00);
      irq = 2'b01;
      ticks(3);
      check("t6_pend", {6'b0, pending}, 8'h01);
      mask_we = 1'b1;
      mask_in = 8'h00;
      tick();
      mask_we = 1'b0;
      check("t6_s1_oldmask", {7'b0, s_intr1}, 8'h01);
      check("t6_mask_new", mask_q, 8'h00);
      int_ret = 1'b1;
      tick();
      int_ret = 1'b0;
      check("t6_ret_in_issue", {7'b0, busy}, 8'h01);
      tick();
      check("t6_still_busy", {7'b0, busy}, 8'h01);
      ret_pulse();
      check("t6_busy_done", {7'b0, busy}, 8'h00);
      irq = 2'b00;
      ticks(4);

      // random irq/int_ret traffic: vector pulses must stay mutually exclusive
      wr_mask(8'h83);
      for (int i = 0; i < 300; i++) begin
         irq     = 2'($urandom_range(0, 3));
         int_ret = ($urandom_range(0, 7) == 0);
         tick();
         check("rnd_excl", {7'b0, s_intr1 & s_intr2}, 8'h00);
      end
      irq     = 2'b00;
      int_ret = 1'b0;
      ticks(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
